// File: rtl/blink_sched.sv
// blink_sched: N-channel LED blink scheduler sharing one prescaler and one sub-counter datapath.
// Optional macro BLINK_SCHED_SYNC_EN commits all channels' led/flg together at scan end.
module blink_sched #(
  parameter int CBITS = 10,
  parameter int N     = 4,
  parameter int DBITS = 4,
  localparam int CW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CW-1:0]    cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [DBITS-1:0] cfg_div,
  output logic [N-1:0]     led,
  output logic [N-1:0]     flg,
  output logic             busy
);

  localparam logic [1:0]    M_OFF   = 2'd0;
  localparam logic [1:0]    M_ON    = 2'd1;
  localparam logic [1:0]    M_BLINK = 2'd2;
  localparam logic [CW:0]   NCH     = (CW+1)'(N);
  localparam logic [CW-1:0] LAST    = CW'(N - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, state_nxt;
  logic [CBITS-1:0] pcnt;
  logic [CW-1:0]    idx, idx_nxt;
  logic [1:0]       mode [N];
  logic [DBITS-1:0] div  [N];
  logic [DBITS-1:0] sub  [N];

  logic             tick, scan, last, cfg_hit, cfg_acc;
  logic [1:0]       new_mode;
  logic [DBITS-1:0] new_sub;
  logic             cur_led, new_led, ev;
  logic [N-1:0]     led_src;

  assign tick      = &pcnt;
  assign scan      = (state == SCAN);
  assign last      = scan && (idx == LAST);
  assign busy      = scan;
  assign cfg_ready = rst_n && (state == IDLE) && !tick;
  assign cfg_hit   = ({1'b0, cfg_ch} < NCH);
  assign cfg_acc   = cfg_valid && cfg_ready && cfg_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcnt <= '0;
    else        pcnt <= pcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: if (tick) begin
        state_nxt = SCAN;
        idx_nxt   = '0;
      end
      SCAN: begin
        if (last) state_nxt = IDLE;
        else      idx_nxt   = idx + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shared service datapath: one channel per scan cycle.
  always_comb begin
    cur_led  = led_src[idx];
    new_mode = mode[idx];
    new_sub  = sub[idx];
    new_led  = cur_led;
    ev       = 1'b0;
    case (mode[idx])
      M_OFF: new_led = 1'b0;
      M_ON:  new_led = 1'b1;
      M_BLINK: begin
        if (sub[idx] == div[idx]) begin
          new_sub = '0;
          new_led = !cur_led;
          ev      = 1'b1;
        end else begin
          new_sub = sub[idx] + 1'b1;
        end
      end
      default: begin
        if (sub[idx] == div[idx]) begin
          new_led  = 1'b0;
          new_mode = M_OFF;
          ev       = 1'b1;
        end else begin
          new_sub = sub[idx] + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mode[i] <= M_OFF;
        div[i]  <= '0;
        sub[i]  <= '0;
      end
    end else if (scan) begin
      mode[idx] <= new_mode;
      sub[idx]  <= new_sub;
    end else if (cfg_acc) begin
      mode[cfg_ch] <= cfg_mode;
      div[cfg_ch]  <= cfg_div;
      sub[cfg_ch]  <= '0;
    end
  end

`ifdef BLINK_SCHED_SYNC_EN
  logic [N-1:0] led_sh, flg_sh, led_sh_nxt, flg_sh_nxt;

  assign led_src = led_sh;

  always_comb begin
    led_sh_nxt      = led_sh;
    flg_sh_nxt      = flg_sh;
    led_sh_nxt[idx] = new_led;
    flg_sh_nxt[idx] = ev;
  end

  // Shadow copies track the scan; outputs load only on the last serviced channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_sh <= '0;
      flg_sh <= '0;
      led    <= '0;
      flg    <= '0;
    end else begin
      flg <= '0;
      if (tick) flg_sh <= '0;
      if (scan) begin
        led_sh <= led_sh_nxt;
        flg_sh <= flg_sh_nxt;
        if (last) begin
          led <= led_sh_nxt;
          flg <= flg_sh_nxt;
        end
      end else if (cfg_acc) begin
        led_sh[cfg_ch] <= cfg_mode[0];
        led[cfg_ch]    <= cfg_mode[0];
      end
    end
  end
`else
  assign led_src = led;

  // Initial led on a config write is 1 for ON/ONESHOT, i.e. mode bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
      flg <= '0;
    end else begin
      flg <= '0;
      if (scan) begin
        led[idx] <= new_led;
        flg[idx] <= ev;
      end else if (cfg_acc) begin
        led[cfg_ch] <= cfg_mode[0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_blink_sched.sv
// tb_blink_sched: directed table, corner sequences and random traffic against a tick-level model.
module tb_blink_sched;
  localparam int CBITS = 4;
  localparam int N     = 3;
  localparam int DBITS = 4;
  localparam int CW    = 2;
  localparam int PER   = 1 << CBITS;
`ifdef BLINK_SCHED_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CW-1:0]    cfg_ch = '0;
  logic [1:0]       cfg_mode = '0;
  logic [DBITS-1:0] cfg_div = '0;
  logic             cfg_ready, busy;
  logic [N-1:0]     led, flg;

  blink_sched #(.CBITS(CBITS), .N(N), .DBITS(DBITS)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_div(cfg_div),
    .led(led), .flg(flg), .busy(busy)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Behavioural model: a whole scan is evaluated at the tick, results are
  // queued for the cycle in which they become visible on the pins.
  typedef struct { int t; int ch; bit l; bit f; } upd_t;
  upd_t         pend[$];
  int           m_pcnt, m_k, m_last_tick;
  int           m_mode[N], m_div[N], m_sub[N];
  bit           m_slog[N];
  bit [N-1:0]   m_led, m_flg;

  typedef struct { int mode; int div; int nticks; bit exp_led; int exp_pulses; } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, m_k);
    end
  endtask

  function automatic bit m_busy();
    return (m_k - m_last_tick) >= 1 && (m_k - m_last_tick) <= N;
  endfunction

  function automatic bit m_tick();
    return m_pcnt == PER - 1;
  endfunction

  function automatic bit m_ready();
    return !m_busy() && !m_tick();
  endfunction

  task automatic model_reset();
    m_pcnt = 0; m_k = 0; m_last_tick = -1000;
    m_led = '0; m_flg = '0;
    pend.delete();
    for (int i = 0; i < N; i++) begin
      m_mode[i] = 0; m_div[i] = 0; m_sub[i] = 0; m_slog[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit acc, input int ch, input int mode, input int dv);
    bit [N-1:0] nl;
    bit [N-1:0] nf;
    upd_t keep[$];
    bit f;
    nl = m_led; nf = '0;
    if (acc && ch < N) begin
      m_mode[ch] = mode; m_div[ch] = dv; m_sub[ch] = 0;
      m_slog[ch] = (mode == 1 || mode == 3);
      nl[ch] = m_slog[ch];
    end
    if (m_tick()) begin
      m_last_tick = m_k;
      for (int i = 0; i < N; i++) begin
        f = 1'b0;
        case (m_mode[i])
          0: m_slog[i] = 1'b0;
          1: m_slog[i] = 1'b1;
          2: if (m_sub[i] == m_div[i]) begin
               m_sub[i] = 0; m_slog[i] = !m_slog[i]; f = 1'b1;
             end else m_sub[i]++;
          default: if (m_sub[i] == m_div[i]) begin
               m_slog[i] = 1'b0; m_mode[i] = 0; f = 1'b1;
             end else m_sub[i]++;
        endcase
        pend.push_back('{t: (SYNC ? m_k + N + 1 : m_k + 2 + i), ch: i, l: m_slog[i], f: f});
      end
    end
    foreach (pend[j]) begin
      if (pend[j].t == m_k + 1) begin
        nl[pend[j].ch] = pend[j].l;
        nf[pend[j].ch] = pend[j].f;
      end else keep.push_back(pend[j]);
    end
    pend = keep;
    m_led = nl; m_flg = nf;
    m_k++;
    m_pcnt = (m_pcnt + 1) % PER;
  endtask

  // One clock cycle: drive inputs, compare current outputs, advance model and DUT.
  task automatic cyc(input bit v, input int ch, input int mode, input int dv, output bit acc);
    cfg_valid = v; cfg_ch = CW'(ch); cfg_mode = 2'(mode); cfg_div = DBITS'(dv);
    chk("led", 32'(led), 32'(m_led));
    chk("flg", 32'(flg), 32'(m_flg));
    chk("busy", 32'(busy), 32'(m_busy()));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_ready()));
    acc = v && m_ready();
    model_step(acc, ch, mode, dv);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0, a);
  endtask

  task automatic write_cfg(input int ch, input int mode, input int dv);
    bit a;
    a = 1'b0;
    for (int i = 0; i < 64 && !a; i++) cyc(1'b1, ch, mode, dv, a);
    chk("cfg_accept_bound", 32'(a), 32'd1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit a;
    int ticks, pulses, n_acc;
    bit rdy;

    tbl[0] = '{mode: 2, div: 2,  nticks: 3, exp_led: 1'b1, exp_pulses: 1};
    tbl[1] = '{mode: 2, div: 2,  nticks: 6, exp_led: 1'b0, exp_pulses: 2};
    tbl[2] = '{mode: 2, div: 0,  nticks: 5, exp_led: 1'b1, exp_pulses: 5};
    tbl[3] = '{mode: 3, div: 1,  nticks: 1, exp_led: 1'b1, exp_pulses: 0};
    tbl[4] = '{mode: 3, div: 1,  nticks: 2, exp_led: 1'b0, exp_pulses: 1};
    tbl[5] = '{mode: 3, div: 0,  nticks: 4, exp_led: 1'b0, exp_pulses: 1};
    tbl[6] = '{mode: 1, div: 3,  nticks: 2, exp_led: 1'b1, exp_pulses: 0};
    tbl[7] = '{mode: 0, div: 5,  nticks: 1, exp_led: 1'b0, exp_pulses: 0};
    tbl[8] = '{mode: 2, div: 15, nticks: 3, exp_led: 1'b0, exp_pulses: 0};
    tbl[9] = '{mode: 3, div: 2,  nticks: 3, exp_led: 1'b0, exp_pulses: 1};

    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_flg", 32'(flg), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_cfg_ready", 32'(cfg_ready), 32'd1);

    // Table: configure channel 1, run a number of ticks, check led and pulse count.
    foreach (tbl[r]) begin
      write_cfg(1, tbl[r].mode, tbl[r].div);
      ticks = 0; pulses = 0;
      for (int i = 0; i < 200 && ticks < tbl[r].nticks; i++) begin
        if (m_tick()) ticks++;
        pulses += int'(flg[1]);
        cyc(1'b0, 0, 0, 0, a);
      end
      for (int i = 0; i < N + 2; i++) begin
        pulses += int'(flg[1]);
        cyc(1'b0, 0, 0, 0, a);
      end
      chk($sformatf("tbl%0d_led1", r), 32'(led[1]), 32'(tbl[r].exp_led));
      chk($sformatf("tbl%0d_pulses", r), 32'(pulses), 32'(tbl[r].exp_pulses));
    end

    // Request raised during a scan stalls, then exactly one write lands.
    for (int i = 0; i < 40 && !m_busy(); i++) cyc(1'b0, 0, 0, 0, a);
    chk("stall_reach_scan", 32'(m_busy()), 32'd1);
    n_acc = 0; a = 1'b0;
    for (int i = 0; i < 40 && !a; i++) begin
      rdy = cfg_ready;
      if (rdy) n_acc++;
      cyc(1'b1, 2, 3, 3, a);
      chk("stall_accept_cycle", 32'(rdy), 32'(a));
    end
    chk("stall_single_write", 32'(n_acc), 32'd1);
    idle(2);
    chk("stall_led2", 32'(led[2]), 32'd1);

    // Out-of-range channel: accepted, nothing changes.
    write_cfg(N, 1, 0);
    idle(3);
    chk("oor_led", 32'(led), 32'(m_led));

    // Write landing in the last cycle before a tick is serviced by that scan.
    for (int i = 0; i < 40 && !(m_pcnt == PER - 2 && m_ready()); i++) cyc(1'b0, 0, 0, 0, a);
    cyc(1'b1, 0, 2, 0, a);
    chk("pretick_accept", 32'(a), 32'd1);
    chk("pretick_is_tick", 32'(m_tick()), 32'd1);
    cfg_valid = 1'b0;
    idle(1);
    chk("pretick_led0_init", 32'(led[0]), 32'd0);
    idle(1);
    chk("pretick_led0_t2", 32'(led[0]), SYNC ? 32'd0 : 32'd1);
    idle(N - 1);
    chk("pretick_led0_end", 32'(led[0]), 32'd1);

    // Random traffic.
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), a);

    // Reset asserted mid-scan discards the scan.
    for (int i = 0; i < 40 && !m_busy(); i++) cyc(1'b0, 0, 0, 0, a);
    rst_n = 1'b0;
    #1;
    chk("midrst_led", 32'(led), 32'd0);
    chk("midrst_flg", 32'(flg), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cfg_ready", 32'(cfg_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("midrst_hold_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("midrst_rel_cfg_ready", 32'(cfg_ready), 32'd1);
    for (int i = 0; i < 200; i++)
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 2), a);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
